// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the CPU data-memory req/ack handshake. A 2**ADDR_W x DATA_W
//   store serves one access per request. A request is accepted in IDLE. The
//   access itself happens WAIT_STATES+1 edges after the request is accepted.
//   ack is a single-cycle pulse.
//   Optional write protection: define DMR_WPROT_EN to reject writes at or
//   above PROTECT_BASE (err=1 with ack). Without it, err is always 0.
module data_mem_responder #(
   parameter int                DATA_W       = 8,
   parameter int                ADDR_W       = 8,
   parameter int                WAIT_STATES  = 2,
   parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hF0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // The wait counter is 4 bits, so WAIT_STATES is limited to 0..15.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ack;
   logic              r_busy;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;

   // The store is zeroed once at power-up only; rst never clears it.
   logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

   logic w_access;
   logic w_prot;
   logic w_commit;

   // The access fires on the last WAIT cycle.
   assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMR_WPROT_EN
   assign w_prot = r_we && (r_addr >= PROTECT_BASE);
`else
   assign w_prot = 1'b0;
`endif

   // A reset during WAIT forces IDLE asynchronously, so a dropped write can
   // never reach the array.
   assign w_commit = w_access && r_we && !w_prot;

   // Handshake FSM: capture on accept, count wait states, then respond.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= WAIT_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_ack   <= 1'b1;
                  r_err   <= w_prot;
                  r_state <= S_RESP;
                  // Reads update rdata. Writes leave the last read value in place.
                  if (!r_we) begin
                     r_rdata <= r_mem[r_addr];
                  end
               end
            end
            S_RESP: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Array write port. It has no reset, so the array can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign ack   = r_ack;
   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule
